dcachemem_nway: RTL and testbench

- Parametrised N-way set-associative data-cache storage array; successor to the one-way 128x64 D-cache memory.
- Adds tag/valid/dirty state per way, tree pseudo-LRU replacement, store-hit merge, and a registered dirty-victim eviction port that feeds the writeback path.
- Sits between the LSQ/memory-stage lookup logic and the D-cache miss/writeback controller.

---
 rtl/dcachemem_nway_pkg.sv | 18 +
 rtl/dcache_plru.sv | 38 +++
 rtl/dcachemem_nway.sv | 138 +++++++++++++
 tb/tb_dcachemem_nway.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/dcachemem_nway_pkg.sv
// Shared constants and helpers for the N-way D-cache storage array.
package dcachemem_nway_pkg;

    localparam bit TRUE  = 1'b1;
    localparam bit FALSE = 1'b0;

    localparam int DEF_NUM_SETS = 64;
    localparam int DEF_NUM_WAYS = 2;
    localparam int DEF_OFF_BITS = 3;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/dcache_plru.sv
// Tree pseudo-LRU: victim walk over the tree bits and the updated tree after an access.
module dcache_plru
    import dcachemem_nway_pkg::*;
#(
    parameter int NUM_WAYS = DEF_NUM_WAYS,
    parameter int TREE_W   = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1,
    parameter int WAY_W    = (NUM_WAYS > 1) ? clog2(NUM_WAYS) : 1
) (
    input  logic [TREE_W-1:0] tree,
    input  logic [WAY_W-1:0]  access_way,
    output logic [WAY_W-1:0]  victim_way,
    output logic [TREE_W-1:0] next_tree
);

    localparam int LVL = clog2(NUM_WAYS);

    // Heap layout: node n has children 2n+1 (left, bit 0) and 2n+2 (right, bit 1).
    always_comb begin
        int node;
        victim_way = '0;
        node = 0;
        for (int l = 0; l < LVL; l++) begin
            victim_way[LVL-1-l] = tree[node];
            node = 2 * node + 1 + int'(tree[node]);
        end
    end

    always_comb begin
        int node;
        next_tree = tree;
        node = 0;
        for (int l = 0; l < LVL; l++) begin
            next_tree[node] = ~access_way[LVL-1-l];
            node = 2 * node + 1 + int'(access_way[LVL-1-l]);
        end
    end

endmodule

// File: rtl/dcachemem_nway.sv
// N-way set-associative D-cache storage: combinational read, tag/valid/dirty per way,
// tree PLRU replacement and a registered dirty-victim eviction port.
module dcachemem_nway
    import dcachemem_nway_pkg::*;
#(
    parameter int NUM_SETS = DEF_NUM_SETS,
    parameter int NUM_WAYS = DEF_NUM_WAYS,
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 64,
    parameter int OFF_BITS = DEF_OFF_BITS
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_dirty,
    output logic              evict_valid,
    output logic [ADDR_W-1:0] evict_addr,
    output logic [DATA_W-1:0] evict_data
);

    localparam int IDX_BITS = clog2(NUM_SETS);
    localparam int TAG_BITS = ADDR_W - IDX_BITS - OFF_BITS;
    localparam int WAY_W    = (NUM_WAYS > 1) ? clog2(NUM_WAYS) : 1;
    localparam int TREE_W   = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;

    typedef logic [WAY_W-1:0] way_t;

    logic [TAG_BITS-1:0] tag_mem  [NUM_SETS][NUM_WAYS];
    logic [DATA_W-1:0]   data_mem [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] valid    [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty    [NUM_SETS];
    logic [TREE_W-1:0]   plru     [NUM_SETS];

    logic [IDX_BITS-1:0] rd_idx, wr_idx;
    logic [TAG_BITS-1:0] rd_tag, wr_tag;
    logic                rd_hit, wr_hit, inv_found, evict_now, rd_plru_upd;
    way_t                rd_way, wr_hit_way, inv_way, wr_way, plru_victim, rd_victim_unused;
    logic [TREE_W-1:0]   wr_next_tree, rd_next_tree;
    logic                offs_unused;

    assign rd_idx = rd_addr[IDX_BITS+OFF_BITS-1:OFF_BITS];
    assign rd_tag = rd_addr[ADDR_W-1:IDX_BITS+OFF_BITS];
    assign wr_idx = wr_addr[IDX_BITS+OFF_BITS-1:OFF_BITS];
    assign wr_tag = wr_addr[ADDR_W-1:IDX_BITS+OFF_BITS];
    assign offs_unused = ^{rd_addr[OFF_BITS-1:0], wr_addr[OFF_BITS-1:0]};

    always_comb begin
        rd_hit = FALSE;
        rd_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid[rd_idx][w] && tag_mem[rd_idx][w] == rd_tag) begin
                rd_hit = TRUE;
                rd_way = way_t'(w);
            end
        end
    end

    assign rd_valid = rd_hit;
    assign rd_data  = rd_hit ? data_mem[rd_idx][rd_way] : '0;

    // Allocation prefers the lowest invalid way; the PLRU only decides among full sets.
    always_comb begin
        wr_hit     = FALSE;
        wr_hit_way = '0;
        inv_found  = FALSE;
        inv_way    = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid[wr_idx][w] && tag_mem[wr_idx][w] == wr_tag) begin
                wr_hit     = TRUE;
                wr_hit_way = way_t'(w);
            end
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid[wr_idx][w]) begin
                inv_found = TRUE;
                inv_way   = way_t'(w);
            end
        end
    end

    assign wr_way = wr_hit ? wr_hit_way : (inv_found ? inv_way : plru_victim);
    assign evict_now = wr_en && !wr_hit && valid[wr_idx][wr_way] && dirty[wr_idx][wr_way];
    assign rd_plru_upd = rd_en && rd_hit && !(wr_en && wr_idx == rd_idx);

    dcache_plru #(.NUM_WAYS(NUM_WAYS), .TREE_W(TREE_W), .WAY_W(WAY_W)) u_plru_wr (
        .tree       (plru[wr_idx]),
        .access_way (wr_way),
        .victim_way (plru_victim),
        .next_tree  (wr_next_tree)
    );

    dcache_plru #(.NUM_WAYS(NUM_WAYS), .TREE_W(TREE_W), .WAY_W(WAY_W)) u_plru_rd (
        .tree       (plru[rd_idx]),
        .access_way (rd_way),
        .victim_way (rd_victim_unused),
        .next_tree  (rd_next_tree)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
                plru[s]  <= '0;
            end
            evict_valid <= 1'b0;
            evict_addr  <= '0;
            evict_data  <= '0;
        end else begin
            evict_valid <= evict_now;
            if (evict_now) begin
                evict_addr <= {tag_mem[wr_idx][wr_way], wr_idx, {OFF_BITS{1'b0}}};
                evict_data <= data_mem[wr_idx][wr_way];
            end
            if (wr_en) begin
                valid[wr_idx][wr_way] <= 1'b1;
                dirty[wr_idx][wr_way] <= wr_hit ? (dirty[wr_idx][wr_way] | wr_dirty) : wr_dirty;
                plru[wr_idx]          <= wr_next_tree;
            end
            if (rd_plru_upd) plru[rd_idx] <= rd_next_tree;
        end
    end

    // A write landing during reset touches only tag/data; its valid bit stays cleared.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            tag_mem[wr_idx][wr_way]  <= wr_tag;
            data_mem[wr_idx][wr_way] <= wr_data;
        end
    end

endmodule

// File: tb/tb_dcachemem_nway.sv
// Bench for dcachemem_nway (64 sets, 2 ways): directed scenarios plus random traffic
// against a line-level model that tracks the most recently used way per set.
module tb_dcachemem_nway;

    logic        clock = 1'b0;
    logic        reset;
    logic        rd_en, wr_en, wr_dirty;
    logic [63:0] rd_addr, wr_addr, wr_data;
    logic [63:0] rd_data, evict_addr, evict_data;
    logic        rd_valid, evict_valid;

    dcachemem_nway dut (
        .clock       (clock),
        .reset       (reset),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_dirty    (wr_dirty),
        .evict_valid (evict_valid),
        .evict_addr  (evict_addr),
        .evict_data  (evict_data)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    bit          mv   [64][2];
    bit          md   [64][2];
    logic [54:0] mt   [64][2];
    logic [63:0] mdat [64][2];
    int          mru  [64];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 64; s++) begin
            mv[s][0] = 0; mv[s][1] = 0;
            md[s][0] = 0; md[s][1] = 0;
            mru[s] = 1;
        end
    endtask

    task automatic model_read(input logic [63:0] a, output bit h, output logic [63:0] d, output int way);
        int i;
        i = int'(a[8:3]);
        h = 0; d = '0; way = 0;
        for (int w = 0; w < 2; w++)
            if (mv[i][w] && mt[i][w] == a[63:9]) begin
                h = 1; d = mdat[i][w]; way = w;
            end
    endtask

    task automatic model_step(input bit re, input logic [63:0] ra, input bit we,
                              input logic [63:0] wa, input logic [63:0] wd, input bit wdirty,
                              output bit ev, output logic [63:0] ea, output logic [63:0] ed);
        bit rh, wh;
        logic [63:0] tmp;
        int rw, ww, i, v;
        model_read(ra, rh, tmp, rw);
        ev = 0; ea = '0; ed = '0;
        if (we) begin
            i = int'(wa[8:3]);
            model_read(wa, wh, tmp, ww);
            if (wh) begin
                mdat[i][ww] = wd;
                md[i][ww]   = md[i][ww] | wdirty;
                mru[i]      = ww;
            end else begin
                v = !mv[i][0] ? 0 : (!mv[i][1] ? 1 : 1 - mru[i]);
                if (mv[i][v] && md[i][v]) begin
                    ev = 1;
                    ea = {mt[i][v], wa[8:3], 3'b000};
                    ed = mdat[i][v];
                end
                mt[i][v] = wa[63:9]; mdat[i][v] = wd;
                mv[i][v] = 1; md[i][v] = wdirty; mru[i] = v;
            end
        end
        if (re && rh && !(we && wa[8:3] == ra[8:3])) mru[int'(ra[8:3])] = rw;
    endtask

    // Drive one cycle's inputs, check the combinational read, clock, then check eviction.
    task automatic do_cycle(input bit re, input logic [63:0] ra, input bit we,
                            input logic [63:0] wa, input logic [63:0] wd, input bit wdirty,
                            input string tag);
        bit h, ev;
        int way;
        logic [63:0] d, ea, ed;
        rd_en = re; rd_addr = ra; wr_en = we; wr_addr = wa; wr_data = wd; wr_dirty = wdirty;
        #1;
        if (re) begin
            model_read(ra, h, d, way);
            check({tag, " rd_valid"}, {63'b0, rd_valid}, {63'b0, h});
            check({tag, " rd_data"}, rd_data, d);
        end
        model_step(re, ra, we, wa, wd, wdirty, ev, ea, ed);
        @(posedge clock);
        #1;
        check({tag, " evict_valid"}, {63'b0, evict_valid}, {63'b0, ev});
        if (ev) begin
            check({tag, " evict_addr"}, evict_addr, ea);
            check({tag, " evict_data"}, evict_data, ed);
        end
        rd_en = 0; wr_en = 0;
    endtask

    task automatic peek(input logic [63:0] a, input bit exp_v, input logic [63:0] exp_d, input string tag);
        rd_en = 0; wr_en = 0; rd_addr = a;
        #1;
        check({tag, " valid"}, {63'b0, rd_valid}, {63'b0, exp_v});
        check({tag, " data"}, rd_data, exp_d);
    endtask

    initial begin
        logic [63:0] a, b;
        reset = 1; rd_en = 1; rd_addr = 64'h1000; wr_en = 0; wr_addr = '0; wr_data = '0; wr_dirty = 0;
        model_reset();
        #3;
        check("reset evict_valid", {63'b0, evict_valid}, 64'd0);
        check("reset evict_addr", evict_addr, 64'd0);
        check("reset evict_data", evict_data, 64'd0);
        check("reset rd_valid", {63'b0, rd_valid}, 64'd0);
        check("reset rd_data", rd_data, 64'd0);
        @(negedge clock); reset = 0;
        @(posedge clock); #1;

        // 1: cold read misses
        do_cycle(1, 64'h1000, 0, 0, 0, 0, "t1 read");
        peek(64'h1000, 0, 64'h0, "t1 miss");

        // 2: clean fill then hit; same set different tag misses
        do_cycle(0, 0, 1, 64'h1000, 64'hAAAA, 0, "t2 fill");
        peek(64'h1000, 1, 64'hAAAA, "t2 hit");
        peek(64'h1200, 0, 64'h0, "t2 other tag");
        do_cycle(1, 64'h1000, 0, 0, 0, 0, "t2 read");

        // 3: read refreshes 0x1000, so the dirty 0x1200 is the victim
        do_cycle(0, 0, 1, 64'h1000, 64'h11, 1, "t3 st1000");
        do_cycle(0, 0, 1, 64'h1200, 64'h22, 1, "t3 st1200");
        do_cycle(1, 64'h1000, 0, 0, 0, 0, "t3 rd1000");
        do_cycle(0, 0, 1, 64'h1400, 64'h33, 0, "t3 fill1400");
        check("t3 evict_valid", {63'b0, evict_valid}, 64'd1);
        check("t3 evict_addr", evict_addr, 64'h1200);
        check("t3 evict_data", evict_data, 64'h22);
        do_cycle(0, 0, 0, 0, 0, 0, "t3 idle");
        check("t3 pulse ends", {63'b0, evict_valid}, 64'd0);
        peek(64'h1000, 1, 64'h11, "t3 keep1000");

        // 4: store hit merges dirty; later evicted with new data
        do_cycle(0, 0, 1, 64'h1000, 64'h44, 0, "t4 fill1000");
        do_cycle(0, 0, 1, 64'h1000, 64'h55, 1, "t4 st1000");
        check("t4 no evict", {63'b0, evict_valid}, 64'd0);
        peek(64'h1000, 1, 64'h55, "t4 hit");
        do_cycle(0, 0, 1, 64'h1200, 64'h66, 0, "t4 fill1200");
        do_cycle(0, 0, 1, 64'h1400, 64'h67, 0, "t4 fill1400");
        check("t4 evict_valid", {63'b0, evict_valid}, 64'd1);
        check("t4 evict_addr", evict_addr, 64'h1000);
        check("t4 evict_data", evict_data, 64'h55);

        // 5: read-during-write returns old data
        do_cycle(0, 0, 1, 64'h2008, 64'h77, 0, "t5 fill");
        rd_en = 1; rd_addr = 64'h2008; wr_en = 1; wr_addr = 64'h2008; wr_data = 64'h88; wr_dirty = 0;
        #1;
        check("t5 old data", rd_data, 64'h77);
        do_cycle(1, 64'h2008, 1, 64'h2008, 64'h88, 0, "t5 rdwr");
        peek(64'h2008, 1, 64'h88, "t5 new data");

        // 6: async reset while an eviction is on the port
        do_cycle(0, 0, 1, 64'h3010, 64'hA1, 1, "t6 a");
        do_cycle(0, 0, 1, 64'h3210, 64'hA2, 1, "t6 b");
        do_cycle(0, 0, 1, 64'h3410, 64'hA3, 1, "t6 c");
        check("t6 evict up", {63'b0, evict_valid}, 64'd1);
        #1 reset = 1;
        #1;
        check("t6 evict_valid drop", {63'b0, evict_valid}, 64'd0);
        check("t6 evict_addr clr", evict_addr, 64'd0);
        check("t6 evict_data clr", evict_data, 64'd0);
        model_reset();
        peek(64'h1000, 0, 64'h0, "t6 miss1000");
        peek(64'h2008, 0, 64'h0, "t6 miss2008");
        wr_en = 1; wr_addr = 64'h3000; wr_data = 64'hBEEF; wr_dirty = 1;
        @(posedge clock); #1;
        @(negedge clock); wr_en = 0; reset = 0;
        @(posedge clock); #1;
        peek(64'h3000, 0, 64'h0, "t6 write in reset");

        // Random traffic over three sets and four tags per set
        for (int n = 0; n < 400; n++) begin
            a = {53'($urandom_range(0, 3)), 2'b0, 6'($urandom_range(0, 2)), 3'($urandom)};
            b = {53'($urandom_range(0, 3)), 2'b0, 6'($urandom_range(0, 2)), 3'($urandom)};
            do_cycle(1'($urandom), a, 1'($urandom), b, {$urandom, $urandom}, 1'($urandom), "rnd");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
